// File: rtl/memref_mp.sv
// Multi-read-port, single-write-port memory with per-port read pipelines, access counters
// and a sticky first-error capture. Optional macro: MEMREF_MP_CONFLICT_CHECK_EN.
module memref_mp #(
    parameter int WIDTH      = 32,
    parameter int SIZE       = 1024,
    parameter int ADDR_W     = 10,
    parameter int NUM_RD     = 2,
    parameter int RD_LATENCY = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]        rd_valid,
    output logic [NUM_RD*WIDTH-1:0]  rd_data,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [31:0]              rd_count,
    output logic [31:0]              wr_count,
    output logic                     err,
    output logic [ADDR_W-1:0]        err_addr
);

    localparam int MEM_AW = (SIZE > 1) ? $clog2(SIZE) : 1;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return 64'(a) < 64'(SIZE);
    endfunction

    logic [WIDTH-1:0]  r_mem [SIZE];
    logic [ADDR_W-1:0] w_rd_addr [NUM_RD];
    logic [NUM_RD-1:0] w_rd_err;
    logic              w_wr_in;
    logic              w_wr_ok;
    logic              w_wr_err;
    logic              w_err_evt;
    logic [ADDR_W-1:0] w_err_addr_evt;
    logic [2:0]        w_rd_num;
    logic [32:0]       w_rd_sum;

    logic [31:0]       r_rd_count;
    logic [31:0]       r_wr_count;
    logic              r_err;
    logic [ADDR_W-1:0] r_err_addr;

    assign w_wr_in  = in_range(wr_addr);
    assign w_wr_ok  = wr_en && w_wr_in;
    assign w_wr_err = wr_en && !w_wr_in;

    // Storage is never reset; writes are simply ignored while reset is held.
    always_ff @(posedge clk) begin
        if (rst && w_wr_ok) begin
            r_mem[wr_addr[MEM_AW-1:0]] <= wr_data;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic                   w_in;
            logic [RD_LATENCY-1:0]  r_vpipe;
            logic [WIDTH-1:0]       r_dpipe [RD_LATENCY];

            assign w_rd_addr[gi] = rd_addr[gi*ADDR_W +: ADDR_W];
            assign w_in          = in_range(w_rd_addr[gi]);

`ifdef MEMREF_MP_CONFLICT_CHECK_EN
            assign w_rd_err[gi] = rd_en[gi] && (!w_in || (w_wr_ok && (w_rd_addr[gi] == wr_addr)));
`else
            assign w_rd_err[gi] = rd_en[gi] && !w_in;
`endif

            // Stage 0 samples the array before this edge's write lands, giving read-first data.
            // Later stages only advance on valid so the output word holds between reads.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_vpipe <= '0;
                    for (int s = 0; s < RD_LATENCY; s++) begin
                        r_dpipe[s] <= '0;
                    end
                end else begin
                    r_vpipe[0] <= rd_en[gi];
                    if (rd_en[gi]) begin
                        r_dpipe[0] <= w_in ? r_mem[w_rd_addr[gi][MEM_AW-1:0]] : '0;
                    end
                    for (int s = 1; s < RD_LATENCY; s++) begin
                        r_vpipe[s] <= r_vpipe[s-1];
                        if (r_vpipe[s-1]) begin
                            r_dpipe[s] <= r_dpipe[s-1];
                        end
                    end
                end
            end

            assign rd_valid[gi]                = r_vpipe[RD_LATENCY-1];
            assign rd_data[gi*WIDTH +: WIDTH]  = r_dpipe[RD_LATENCY-1];
        end
    endgenerate

    // Write address wins, then the lowest-numbered failing read port.
    always_comb begin
        w_err_evt      = 1'b0;
        w_err_addr_evt = '0;
        for (int i = NUM_RD - 1; i >= 0; i--) begin
            if (w_rd_err[i]) begin
                w_err_evt      = 1'b1;
                w_err_addr_evt = w_rd_addr[i];
            end
        end
        if (w_wr_err) begin
            w_err_evt      = 1'b1;
            w_err_addr_evt = wr_addr;
        end
    end

    always_comb begin
        w_rd_num = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            w_rd_num = w_rd_num + 3'(rd_en[i]);
        end
    end

    assign w_rd_sum = {1'b0, r_rd_count} + 33'(w_rd_num);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_count <= '0;
            r_wr_count <= '0;
            r_err      <= 1'b0;
            r_err_addr <= '0;
        end else begin
            r_rd_count <= w_rd_sum[32] ? 32'hFFFF_FFFF : w_rd_sum[31:0];
            if (w_wr_ok && (r_wr_count != 32'hFFFF_FFFF)) begin
                r_wr_count <= r_wr_count + 32'd1;
            end
            if (!r_err && w_err_evt) begin
                r_err      <= 1'b1;
                r_err_addr <= w_err_addr_evt;
            end
        end
    end

    assign rd_count = r_rd_count;
    assign wr_count = r_wr_count;
    assign err      = r_err;
    assign err_addr = r_err_addr;

endmodule
